// File: rtl/sipo_pkg.sv
// Shared types for the serial-in/parallel-out deserializer.
package sipo_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } sipo_state_e;

endpackage

// File: rtl/sipo_out_buf.sv
// One-entry valid/ready holding register for completed words.
// A new word is dropped, and overrun is pulsed, when the entry is full and not draining.
module sipo_out_buf #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             par_ready,
    output logic             par_valid,
    output logic [WIDTH-1:0] par_data,
    output logic             overrun
);

    logic             par_valid_q, par_valid_d;
    logic [WIDTH-1:0] par_data_q, par_data_d;
    logic             overrun_q, overrun_d;

    always_comb begin
        par_valid_d = par_valid_q;
        par_data_d  = par_data_q;
        overrun_d   = 1'b0;
        if (wr_en) begin
            // A draining entry can be refilled in the same cycle.
            if (!par_valid_q || par_ready) begin
                par_valid_d = 1'b1;
                par_data_d  = wr_data;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (par_valid_q && par_ready) begin
            par_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par_valid_q <= 1'b0;
            par_data_q  <= '0;
            overrun_q   <= 1'b0;
        end else begin
            par_valid_q <= par_valid_d;
            par_data_q  <= par_data_d;
            overrun_q   <= overrun_d;
        end
    end

    assign par_valid = par_valid_q;
    assign par_data  = par_data_q;
    assign overrun   = overrun_q;

endmodule

// File: rtl/sipo_deser.sv
// Serial-in/parallel-out deserializer: frames strobed bits on a start marker, packs WIDTH
// bits per word and streams words back-to-back into a one-entry valid/ready buffer.
//
// Handshakes: input bits are consumed whenever sin_valid is high (no backpressure);
// an output word transfers on a cycle where par_valid && par_ready, and par_data is
// stable while par_valid && !par_ready.
module sipo_deser
    import sipo_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sin_valid,
    input  logic             sin_data,
    input  logic             sin_start,
    output logic             par_valid,
    input  logic             par_ready,
    output logic [WIDTH-1:0] par_data,
    output logic             overrun,
    output logic             frame_err,
    output sipo_state_e      dbg_state
);

    localparam int CW = $clog2(WIDTH + 1);

    sipo_state_e      state_q, state_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             frame_err_q, frame_err_d;

    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] first_bit_word;
    logic             wr_en;
    logic [WIDTH-1:0] wr_data;

    always_comb begin
        if (MSB_FIRST) begin
            shifted        = {sreg_q[WIDTH-2:0], sin_data};
            first_bit_word = {{(WIDTH-1){1'b0}}, sin_data};
        end else begin
            shifted        = {sin_data, sreg_q[WIDTH-1:1]};
            first_bit_word = {sin_data, {(WIDTH-1){1'b0}}};
        end
    end

    always_comb begin
        state_d     = state_q;
        sreg_d      = sreg_q;
        cnt_d       = cnt_q;
        frame_err_d = 1'b0;
        wr_en       = 1'b0;
        wr_data     = shifted;
        case (state_q)
            IDLE: begin
                if (sin_valid && sin_start) begin
                    state_d = SHIFT;
                    sreg_d  = first_bit_word;
                    cnt_d   = CW'(1);
                end
            end
            SHIFT: begin
                if (sin_valid && sin_start) begin
                    // Start with a partial word pending: discard it and restart framing.
                    frame_err_d = (cnt_q != '0);
                    sreg_d      = first_bit_word;
                    cnt_d       = CW'(1);
                end else if (sin_valid) begin
                    sreg_d = shifted;
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        wr_en = 1'b1;
                        cnt_d = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            sreg_q      <= '0;
            cnt_q       <= '0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sreg_q      <= sreg_d;
            cnt_q       <= cnt_d;
            frame_err_q <= frame_err_d;
        end
    end

    sipo_out_buf #(.WIDTH(WIDTH)) u_out_buf (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .par_ready (par_ready),
        .par_valid (par_valid),
        .par_data  (par_data),
        .overrun   (overrun)
    );

    assign frame_err = frame_err_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_sipo_deser.sv
// Directed bench for sipo_deser: an MSB-first and an LSB-first instance share the same stimulus.
module tb_sipo_deser;
    import sipo_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sin_valid = 1'b0;
    logic sin_data = 1'b0;
    logic sin_start = 1'b0;
    logic par_ready = 1'b1;

    logic        m_valid, m_overrun, m_ferr;
    logic [3:0]  m_data;
    sipo_state_e m_state;
    logic        l_valid, l_overrun, l_ferr;
    logic [3:0]  l_data;
    sipo_state_e l_state;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sipo_deser #(.WIDTH(4), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .rst(rst), .sin_valid(sin_valid), .sin_data(sin_data), .sin_start(sin_start),
        .par_valid(m_valid), .par_ready(par_ready), .par_data(m_data),
        .overrun(m_overrun), .frame_err(m_ferr), .dbg_state(m_state)
    );

    sipo_deser #(.WIDTH(4), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rst(rst), .sin_valid(sin_valid), .sin_data(sin_data), .sin_start(sin_start),
        .par_valid(l_valid), .par_ready(par_ready), .par_data(l_data),
        .overrun(l_overrun), .frame_err(l_ferr), .dbg_state(l_state)
    );

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present one input vector for one clock edge; outputs are sampled 1 time unit after the edge.
    task automatic step(input logic v, input logic st, input logic d);
        sin_valid = v;
        sin_start = st;
        sin_data  = d;
        @(posedge clk);
        #1;
        sin_valid = 1'b0;
        sin_start = 1'b0;
        sin_data  = 1'b0;
    endtask

    task automatic check_m(input string tag, input logic v, input logic [3:0] d,
                           input logic ovr, input logic fe);
        check({tag, "_valid"}, {3'b0, m_valid}, {3'b0, v});
        check({tag, "_data"}, m_data, d);
        check({tag, "_overrun"}, {3'b0, m_overrun}, {3'b0, ovr});
        check({tag, "_frame_err"}, {3'b0, m_ferr}, {3'b0, fe});
    endtask

    initial begin
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk);
        #1;
        check_m("por", 1'b0, 4'h0, 1'b0, 1'b0);
        check("por_state", {3'b0, m_state}, {3'b0, IDLE});

        // Bits without a start marker are ignored in IDLE.
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, 1'b1);
            check_m("idle_ignore", 1'b0, 4'h0, 1'b0, 1'b0);
        end
        check("idle_ignore_state", {3'b0, m_state}, {3'b0, IDLE});

        // Basic word 1,0,1,1 with consumer ready.
        par_ready = 1'b1;
        step(1'b1, 1'b1, 1'b1);
        check("basic_state", {3'b0, m_state}, {3'b0, SHIFT});
        check("basic_b1_valid", {3'b0, m_valid}, 4'h0);
        step(1'b1, 1'b0, 1'b0);
        check("basic_b2_valid", {3'b0, m_valid}, 4'h0);
        step(1'b1, 1'b0, 1'b1);
        check("basic_b3_valid", {3'b0, m_valid}, 4'h0);
        step(1'b1, 1'b0, 1'b1);
        check_m("basic_word", 1'b1, 4'hB, 1'b0, 1'b0);
        check("basic_lsb_valid", {3'b0, l_valid}, 4'h1);
        check("basic_lsb_data", l_data, 4'hD);
        step(1'b0, 1'b0, 1'b0);
        check_m("basic_drain", 1'b0, 4'hB, 1'b0, 1'b0);
        check("basic_lsb_drain", {3'b0, l_valid}, 4'h0);

        // Asynchronous reset between clock edges.
        #2 rst = 1'b1;
        #1;
        check_m("async_rst", 1'b0, 4'h0, 1'b0, 1'b0);
        check("async_rst_state", {3'b0, m_state}, {3'b0, IDLE});
        check("async_rst_lsb_data", l_data, 4'h0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Backpressure: B then 6 back-to-back, second word overruns.
        par_ready = 1'b0;
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        check_m("bp_first", 1'b1, 4'hB, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        check_m("bp_bit7", 1'b1, 4'hB, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        check_m("bp_overrun", 1'b1, 4'hB, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        check_m("bp_hold", 1'b1, 4'hB, 1'b0, 1'b0);
        par_ready = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        check_m("bp_release", 1'b0, 4'hB, 1'b0, 1'b0);

        // Framing error: start,1,1 then start,1,1,0 -> word 0,1,1,0.
        step(1'b1, 1'b1, 1'b1);
        check_m("fe_first_start", 1'b0, 4'hB, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0);
        check_m("fe_pulse", 1'b0, 4'hB, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        check_m("fe_clear", 1'b0, 4'hB, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        check_m("fe_word", 1'b1, 4'h6, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);

        // Reset mid-word discards the partial word; next start frames cleanly.
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1;
        check_m("midword_rst", 1'b0, 4'h0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        step(1'b1, 1'b1, 1'b1);
        check_m("post_rst_start", 1'b0, 4'h0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        check_m("post_rst_word", 1'b1, 4'h9, 1'b0, 1'b0);
        check("post_rst_lsb", l_data, 4'h9);

        // Streaming continues without a new start after a completed word.
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        check_m("stream_word", 1'b1, 4'h5, 1'b0, 1'b0);
        check("stream_lsb", l_data, 4'hA);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
